// File: rtl/bus_simple_pkg.sv
// Shared state encoding, constants and request payload for the simple-bus arbiter.
package bus_simple_pkg;

    localparam int unsigned BUS_W = 32;

    typedef logic [1:0] arb_state_e;
    localparam arb_state_e ARB_IDLE  = 2'd0;
    localparam arb_state_e ARB_ISSUE = 2'd1;
    localparam arb_state_e ARB_WAIT  = 2'd2;

    localparam logic [31:0] BUS_ERR_RDATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic               write;
        logic [BUS_W-1:0]   addr;
        logic [BUS_W-1:0]   wdata;
        logic [BUS_W/8-1:0] wstrb;
    } bus_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_M = 2
) (
    input  logic [NUM_M-1:0]         req,
    input  logic [$clog2(NUM_M)-1:0] ptr,
    output logic [NUM_M-1:0]         gnt,
    output logic [$clog2(NUM_M)-1:0] idx,
    output logic                     any
);
    localparam int unsigned IDX_W = $clog2(NUM_M);

    logic [IDX_W-1:0] j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int unsigned k = 0; k < NUM_M; k++) begin
            j = IDX_W'((32'(ptr) + k) % NUM_M);
            if (!any && req[j]) begin
                gnt[j] = 1'b1;
                idx    = j;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_simple_arb.sv
// N-master to 1-slave round-robin arbiter for the simple 32-bit bus with variable slave latency.
// Optional WAIT-state timeout with error response and err_timeout port: BUS_SIMPLE_ARB_TIMEOUT_EN.
module bus_simple_arb
    import bus_simple_pkg::*;
#(
    parameter int unsigned NUM_M       = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_M-1:0]           m_valid,
    input  logic [NUM_M-1:0]           m_write,
    input  logic [NUM_M*ADDR_W-1:0]    m_addr,
    input  logic [NUM_M*DATA_W-1:0]    m_wdata,
    input  logic [NUM_M*DATA_W/8-1:0]  m_wstrb,
    output logic [NUM_M-1:0]           m_ready,
    output logic [NUM_M-1:0]           m_rvalid,
    output logic [DATA_W-1:0]          m_rdata,
    output logic                       s_valid,
    output logic                       s_write,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W-1:0]          s_wdata,
    output logic [DATA_W/8-1:0]        s_wstrb,
    input  logic                       s_ready,
    input  logic [DATA_W-1:0]          s_rdata,
    input  logic                       s_rvalid,
    output logic                       busy,
    output logic [$clog2(NUM_M)-1:0]   grant_id,
`ifdef BUS_SIMPLE_ARB_TIMEOUT_EN
    output logic                       err_timeout,
`endif
    output logic                       err_overrun,
    output logic                       err_stray
);
    localparam int unsigned IDX_W  = $clog2(NUM_M);
    localparam int unsigned STRB_W = DATA_W / 8;

    if (NUM_M < 2 || NUM_M > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("bus_simple_arb: unsupported NUM_M or TIMEOUT_CYC");
    end

    logic [ADDR_W-1:0] in_addr  [NUM_M];
    logic [DATA_W-1:0] in_wdata [NUM_M];
    logic [STRB_W-1:0] in_wstrb [NUM_M];

    for (genvar i = 0; i < NUM_M; i++) begin : g_unpack
        assign in_addr[i]  = m_addr[i*ADDR_W +: ADDR_W];
        assign in_wdata[i] = m_wdata[i*DATA_W +: DATA_W];
        assign in_wstrb[i] = m_wstrb[i*STRB_W +: STRB_W];
    end

    arb_state_e        state_q, state_d;
    logic [NUM_M-1:0]  slot_v_q, slot_write_q;
    logic [ADDR_W-1:0] slot_addr_q  [NUM_M];
    logic [DATA_W-1:0] slot_wdata_q [NUM_M];
    logic [STRB_W-1:0] slot_wstrb_q [NUM_M];
    logic [IDX_W-1:0]  rr_q;

    logic              in_wait, in_svc, take, win_any;
    logic              rsp_ok, rsp_wrong, stray, timeout_hit, done;
    logic [NUM_M-1:0]  svc_oh, accept, cand, win_oh;
    logic [IDX_W-1:0]  win_idx;

    assign in_wait = (state_q == ARB_WAIT);
    assign in_svc  = (state_q != ARB_IDLE);

    // A master in service may not post again until its response cycle has passed.
    always_comb begin
        svc_oh = '0;
        for (int i = 0; i < NUM_M; i++) begin
            svc_oh[i] = in_svc && (grant_id == IDX_W'(i));
        end
    end

    assign accept = m_valid & ~slot_v_q & ~svc_oh;
    assign cand   = slot_v_q | accept;

    rr_arbiter #(.NUM_M(NUM_M)) u_rr (
        .req (cand),
        .ptr (rr_q),
        .gnt (win_oh),
        .idx (win_idx),
        .any (win_any)
    );

    assign take      = (state_q == ARB_IDLE) && win_any;
    assign rsp_ok    = in_wait && (s_write ? s_ready : s_rvalid);
    assign rsp_wrong = in_wait && (s_write ? s_rvalid : s_ready);
    assign stray     = (!in_wait && (s_ready || s_rvalid)) || rsp_wrong;
    assign done      = rsp_ok || timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ARB_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (win_any) state_d = ARB_ISSUE;
            ARB_ISSUE: state_d = ARB_WAIT;
            ARB_WAIT:  if (done) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Pending slots; a winner taken straight from m_valid never occupies its slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_v_q     <= '0;
            slot_write_q <= '0;
            for (int i = 0; i < NUM_M; i++) begin
                slot_addr_q[i]  <= '0;
                slot_wdata_q[i] <= '0;
                slot_wstrb_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_M; i++) begin
                if (take && win_oh[i]) begin
                    slot_v_q[i] <= 1'b0;
                end else if (accept[i]) begin
                    slot_v_q[i]     <= 1'b1;
                    slot_write_q[i] <= m_write[i];
                    slot_addr_q[i]  <= in_addr[i];
                    slot_wdata_q[i] <= in_wdata[i];
                    slot_wstrb_q[i] <= in_wstrb[i];
                end
            end
        end
    end

    // Issue register doubles as the s_* outputs, which hold their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_write  <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_wstrb  <= '0;
            grant_id <= '0;
            rr_q     <= '0;
        end else if (take) begin
            if (slot_v_q[win_idx]) begin
                s_write <= slot_write_q[win_idx];
                s_addr  <= slot_addr_q[win_idx];
                s_wdata <= slot_wdata_q[win_idx];
                s_wstrb <= slot_wstrb_q[win_idx];
            end else begin
                s_write <= m_write[win_idx];
                s_addr  <= in_addr[win_idx];
                s_wdata <= in_wdata[win_idx];
                s_wstrb <= in_wstrb[win_idx];
            end
            grant_id <= win_idx;
            rr_q     <= (32'(win_idx) == NUM_M - 1) ? '0 : win_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_overrun <= 1'b0;
            err_stray   <= 1'b0;
        end else begin
            err_overrun <= err_overrun | (|(m_valid & ~accept));
            err_stray   <= err_stray | stray;
        end
    end

    assign s_valid = (state_q == ARB_ISSUE);
    assign busy    = in_svc;

    // Response routing is combinational so the master sees it in the slave's response cycle.
    always_comb begin
        m_ready  = '0;
        m_rvalid = '0;
        m_rdata  = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_id == IDX_W'(i)) begin
                m_ready[i]  = in_wait && s_write && (s_ready || timeout_hit);
                m_rvalid[i] = in_wait && !s_write && (s_rvalid || timeout_hit);
            end
        end
        if (in_wait && !s_write) begin
            if (s_rvalid)         m_rdata = s_rdata;
            else if (timeout_hit) m_rdata = DATA_W'(BUS_ERR_RDATA);
        end
    end

`ifdef BUS_SIMPLE_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] to_cnt_q;

    // Fires in the TIMEOUT_CYC-th WAIT cycle when the slave stays silent.
    assign timeout_hit = in_wait && !rsp_ok && (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q    <= '0;
            err_timeout <= 1'b0;
        end else begin
            to_cnt_q <= (in_wait && !done) ? to_cnt_q + CNT_W'(1) : '0;
            if (timeout_hit) err_timeout <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_bus_simple_arb.sv
// Scoreboard bench for bus_simple_arb: transaction-level reference model feeds expected-issue and
// expected-response queues; a negedge monitor pops and compares whenever the DUT presents output.
`timescale 1ns/1ps
module tb_bus_simple_arb;
    import bus_simple_pkg::*;

    localparam int unsigned NM = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int          TO_CYC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NM-1:0]    m_valid, m_write, m_ready, m_rvalid;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wdata;
    logic [NM*SW-1:0] m_wstrb;
    logic [DW-1:0]    m_rdata, s_wdata, s_rdata;
    logic [AW-1:0]    s_addr;
    logic [SW-1:0]    s_wstrb;
    logic             s_valid, s_write, s_ready, s_rvalid, busy, err_overrun, err_stray;
    logic [1:0]       grant_id;
`ifdef BUS_SIMPLE_ARB_TIMEOUT_EN
    logic             err_timeout;
`endif

    bus_simple_arb #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
        .busy(busy), .grant_id(grant_id),
`ifdef BUS_SIMPLE_ARB_TIMEOUT_EN
        .err_timeout(err_timeout),
`endif
        .err_overrun(err_overrun), .err_stray(err_stray)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    typedef struct { int cyc; int m; logic w; logic [31:0] a; logic [31:0] d; logic [3:0] s; } iss_t;
    typedef struct { int iss; int rsp; int m; logic w; logic [31:0] d; } rsp_t;
    iss_t iss_q[$];
    rsp_t rsp_q[$];

    // Reference model state: pending requests, per-master service end, arbiter free cycle.
    bus_req_t pend_req [NM];
    logic     pend     [NM];
    int       svc_end  [NM];
    int       rr_ptr, free_cyc;
    logic     exp_ovr, exp_stray, exp_to, silent;

    bus_req_t      st_req [NM];
    logic [NM-1:0] st_v;
    logic          st_stray;

    int          sl_cyc = -1;
    logic        sl_w;
    logic [31:0] sl_d;

    function automatic int lat_of(input logic [31:0] a);
        return int'(a[3:0] % 4'd5) + 1;
    endfunction

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return (a == 32'h1000) ? 32'h1234_5678 : ((a * 32'h9E37_79B9) ^ 32'h0F0F_0F0F);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NM; i++) begin
            pend[i] = 1'b0;
            svc_end[i] = -1;
        end
        rr_ptr = 0;
        free_cyc = 0;
        exp_ovr = 1'b0;
        exp_stray = 1'b0;
        exp_to = 1'b0;
    endtask

    task automatic model_cycle();
        int w;
        int l;
        for (int i = 0; i < NM; i++) begin
            if (st_v[i]) begin
                if (pend[i] || cyc <= svc_end[i]) exp_ovr = 1'b1;
                else begin
                    pend[i] = 1'b1;
                    pend_req[i] = st_req[i];
                end
            end
        end
        if (cyc < free_cyc) return;
        w = -1;
        for (int k = 0; k < NM; k++)
            if (w < 0 && pend[(rr_ptr + k) % NM]) w = (rr_ptr + k) % NM;
        if (w < 0) return;
        pend[w] = 1'b0;
        rr_ptr = (w + 1) % NM;
        l = silent ? TO_CYC : lat_of(pend_req[w].addr);
        iss_q.push_back('{cyc + 1, w, pend_req[w].write, pend_req[w].addr,
                          pend_req[w].wdata, pend_req[w].wstrb});
        rsp_q.push_back('{cyc + 1, cyc + 1 + l, w, pend_req[w].write,
                          pend_req[w].write ? 32'h0 :
                          (silent ? BUS_ERR_RDATA : rd_of(pend_req[w].addr))});
        svc_end[w] = cyc + 1 + l;
        free_cyc = cyc + 2 + l;
        if (silent) exp_to = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        m_valid = st_v;
        for (int i = 0; i < NM; i++) begin
            m_write[i] = st_req[i].write;
            m_addr[i*AW +: AW] = st_req[i].addr;
            m_wdata[i*DW +: DW] = st_req[i].wdata;
            m_wstrb[i*SW +: SW] = st_req[i].wstrb;
        end
        s_ready = 1'b0;
        s_rvalid = 1'b0;
        s_rdata = $urandom;
        if (cyc == sl_cyc) begin
            if (sl_w) s_ready = 1'b1;
            else begin
                s_rvalid = 1'b1;
                s_rdata = sl_d;
            end
        end
        if (st_stray) begin
            s_rvalid = 1'b1;
            exp_stray = 1'b1;
        end
        model_cycle();
        st_v = '0;
        st_stray = 1'b0;
    endtask

    task automatic post(input int m, input logic w, input logic [31:0] a, input logic [3:0] s);
        st_v[m] = 1'b1;
        st_req[m] = '{write: w, addr: a, wdata: $urandom, wstrb: s};
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (iss_q.size() + rsp_q.size()) > 0; k++) step();
        if ((iss_q.size() + rsp_q.size()) > 0) begin
            chk("drain timeout", 32'(iss_q.size() + rsp_q.size()), 32'd0);
            iss_q.delete();
            rsp_q.delete();
        end
        step();
    endtask

    task automatic chk_sticky(input string tag);
        chk({tag, " err_overrun"}, 32'(err_overrun), 32'(exp_ovr));
        chk({tag, " err_stray"}, 32'(err_stray), 32'(exp_stray));
`ifdef BUS_SIMPLE_ARB_TIMEOUT_EN
        chk({tag, " err_timeout"}, 32'(err_timeout), 32'(exp_to));
`endif
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " m_ready"}, 32'(m_ready), 32'd0);
        chk({tag, " m_rvalid"}, 32'(m_rvalid), 32'd0);
        chk({tag, " m_rdata"}, m_rdata, 32'd0);
        chk({tag, " s_valid"}, 32'(s_valid), 32'd0);
        chk({tag, " s_write"}, 32'(s_write), 32'd0);
        chk({tag, " s_addr"}, s_addr, 32'd0);
        chk({tag, " s_wdata"}, s_wdata, 32'd0);
        chk({tag, " s_wstrb"}, 32'(s_wstrb), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " grant_id"}, 32'(grant_id), 32'd0);
        chk({tag, " err_overrun"}, 32'(err_overrun), 32'd0);
        chk({tag, " err_stray"}, 32'(err_stray), 32'd0);
`ifdef BUS_SIMPLE_ARB_TIMEOUT_EN
        chk({tag, " err_timeout"}, 32'(err_timeout), 32'd0);
`endif
    endtask

    // Asynchronous reset mid-cycle; outputs must drop at once and pending work is abandoned.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk_zero(tag);
        iss_q.delete();
        rsp_q.delete();
        model_reset();
        sl_cyc = -1;
        m_valid = '0;
        s_ready = 1'b0;
        s_rvalid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Slave: responds after an address-derived latency unless silenced.
    always @(negedge clk) begin
        if (!rst && s_valid && !silent) begin
            sl_cyc = cyc + lat_of(s_addr);
            sl_w = s_write;
            sl_d = rd_of(s_addr);
        end
    end

    always @(negedge clk) begin : mon
        iss_t e;
        rsp_t r;
        logic eb;
        if (!rst) begin
            eb = (rsp_q.size() > 0) && (cyc >= rsp_q[0].iss);
            chk("busy", 32'(busy), 32'(eb));
            if (eb) chk("grant_id", 32'(grant_id), 32'(rsp_q[0].m));
            if (s_valid) begin
                if (iss_q.size() == 0) chk("unexpected s_valid", 32'(s_valid), 32'd0);
                else begin
                    e = iss_q.pop_front();
                    chk("issue cycle", 32'(cyc), 32'(e.cyc));
                    chk("s_write", 32'(s_write), 32'(e.w));
                    chk("s_addr", s_addr, e.a);
                    chk("s_wdata", s_wdata, e.d);
                    chk("s_wstrb", 32'(s_wstrb), 32'(e.s));
                end
            end else if (iss_q.size() > 0 && cyc >= iss_q[0].cyc) begin
                chk("missing s_valid", 32'(s_valid), 32'd1);
                void'(iss_q.pop_front());
            end
            if ((m_ready | m_rvalid) != '0) begin
                if (rsp_q.size() == 0) chk("unexpected response", 32'(m_ready | m_rvalid), 32'd0);
                else begin
                    r = rsp_q.pop_front();
                    chk("response cycle", 32'(cyc), 32'(r.rsp));
                    chk("m_ready", 32'(m_ready), r.w ? (32'd1 << r.m) : 32'd0);
                    chk("m_rvalid", 32'(m_rvalid), r.w ? 32'd0 : (32'd1 << r.m));
                    if (!r.w) chk("m_rdata", m_rdata, r.d);
                end
            end else if (rsp_q.size() > 0 && cyc >= rsp_q[0].rsp) begin
                chk("missing response", 32'(m_ready | m_rvalid), 32'(1) << rsp_q[0].m);
                void'(rsp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_valid = '0;
        m_write = '0;
        m_addr = '0;
        m_wdata = '0;
        m_wstrb = '0;
        s_ready = 1'b0;
        s_rvalid = 1'b0;
        s_rdata = '0;
        st_v = '0;
        st_stray = 1'b0;
        silent = 1'b0;
        for (int i = 0; i < NM; i++) st_req[i] = '0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // M0 read of 0x1000, 1-cycle slave.
        post(0, 1'b0, 32'h1000, 4'hF);
        step();
        drain();
        chk_sticky("read");
        do_reset("reset2");

        // M0 and M1 writes in the same cycle: M0 first, then M1.
        post(0, 1'b1, 32'h0000_0A10, 4'hF);
        post(1, 1'b1, 32'h0000_0B20, 4'hC);
        step();
        drain();
        chk_sticky("dual write");
        do_reset("reset3");

        // M1 write to a 5-cycle-latency slave address with partial strobes.
        post(1, 1'b1, 32'h2004, 4'b0011);
        step();
        drain();
        chk_sticky("slow write");
        do_reset("reset4");

        // M0 pulses twice before its response: one transaction, overrun flagged.
        post(0, 1'b0, 32'h1000, 4'hF);
        step();
        post(0, 1'b0, 32'h5555_0000, 4'hF);
        step();
        drain();
        chk_sticky("overrun");
        do_reset("reset5");

        // Stray s_rvalid while idle.
        st_stray = 1'b1;
        step();
        drain();
        chk_sticky("stray");
        do_reset("reset6");

        // Reset in the middle of a slow read abandons it.
        post(2, 1'b0, 32'h3004, 4'hF);
        step();
        step();
        step();
        do_reset("abandon");

        // Randomised traffic from all masters, including colliding and overrunning pulses.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NM; i++)
                if ($urandom_range(3) == 0)
                    post(i, 1'($urandom_range(1)), $urandom, 4'($urandom));
            step();
        end
        drain();
        chk_sticky("random");

`ifdef BUS_SIMPLE_ARB_TIMEOUT_EN
        do_reset("reset7");
        silent = 1'b1;
        post(0, 1'b0, 32'h3000, 4'hF);
        step();
        drain();
        chk_sticky("timeout");
        post(1, 1'b0, 32'h3010, 4'hF);
        repeat (6) step();
        do_reset("timeout abandon");
        silent = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
